// File: rtl/morse_tx_controller.sv
// morse_tx_controller: sends one Morse letter (S..Z) per accepted request onto led_out.
// Define MORSE_QUEUE_EN to add a one-entry holding register for back-to-back letters.
module morse_tx_controller #(
   parameter int unsigned TICK_DIV  = 25000000,
   parameter int unsigned GAP_TICKS = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_valid,
   input  logic [2:0] req_code,
   output logic       req_ready,
   input  logic       abort,
   output logic       led_out,
   output logic       busy,
   output logic       done
);

   localparam int unsigned PAT_W = 16;
   localparam int unsigned LEN_W = 5;
   localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
   localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(TICK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(GAP_TICKS);
   localparam logic             NO_GAP     = (GAP_TICKS == 0);
`ifdef MORSE_QUEUE_EN
   localparam logic             READY_BUSY = 1'b1;
`else
   localparam logic             READY_BUSY = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t           state;
   logic [PAT_W-1:0] shift_reg;
   logic [LEN_W-1:0] bits_left;
   logic [DIV_W-1:0] divider;
   logic [GAP_W-1:0] gap_left;

   logic             transfer_c;
   logic             tick_c;
   logic             letter_end_c;
   logic             chain_c;
   logic             start_c;
   logic [2:0]       chain_code_c;
   logic [2:0]       start_code_c;
   logic [PAT_W-1:0] pat_c;
   logic [LEN_W-1:0] len_c;

   assign transfer_c   = req_valid && req_ready;
   assign tick_c       = (divider == '0);
   assign letter_end_c = tick_c &&
                         (((state == SEND) && (bits_left == LEN_W'(1)) && NO_GAP) ||
                          ((state == GAP) && (gap_left == GAP_W'(1))));

`ifdef MORSE_QUEUE_EN
   logic       hold_valid;
   logic [2:0] hold_code;

   // A finishing letter chains straight into the held letter, or into a same-edge request.
   assign chain_c      = letter_end_c && (hold_valid || transfer_c);
   assign chain_code_c = hold_valid ? hold_code : req_code;
`else
   assign chain_c      = 1'b0;
   assign chain_code_c = req_code;
`endif

   // A transfer in IDLE beats a coincident abort; a busy abort beats chaining.
   assign start_c      = (state == IDLE) ? transfer_c : (!abort && chain_c);
   assign start_code_c = (state == IDLE) ? req_code : chain_code_c;

   // Pattern ROM: left-aligned, MSB sent first, one bit per time unit.
   always_comb begin
      pat_c = '0;
      len_c = '0;
      case (start_code_c)
         3'd0: begin pat_c = {5'b10101, 11'b0};          len_c = 5'd5;  end
         3'd1: begin pat_c = {3'b111, 13'b0};            len_c = 5'd3;  end
         3'd2: begin pat_c = {7'b1010111, 9'b0};         len_c = 5'd7;  end
         3'd3: begin pat_c = {9'b101010111, 7'b0};       len_c = 5'd9;  end
         3'd4: begin pat_c = {9'b101110111, 7'b0};       len_c = 5'd9;  end
         3'd5: begin pat_c = {11'b11101010111, 5'b0};    len_c = 5'd11; end
         3'd6: begin pat_c = {13'b1110101110111, 3'b0};  len_c = 5'd13; end
         3'd7: begin pat_c = {11'b11101110101, 5'b0};    len_c = 5'd11; end
         default: begin pat_c = '0;                      len_c = '0;    end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         shift_reg <= '0;
         bits_left <= '0;
         divider   <= '0;
         gap_left  <= '0;
         led_out   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         req_ready <= 1'b1;
`ifdef MORSE_QUEUE_EN
         hold_valid <= 1'b0;
         hold_code  <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (start_c) begin
            state     <= SEND;
            shift_reg <= pat_c;
            bits_left <= len_c;
            divider   <= DIV_RELOAD;
            gap_left  <= '0;
            led_out   <= pat_c[PAT_W-1];
            busy      <= 1'b1;
            req_ready <= READY_BUSY;
            done      <= (state != IDLE);
`ifdef MORSE_QUEUE_EN
            hold_valid <= 1'b0;
`endif
         end else if ((state != IDLE) && (abort || letter_end_c)) begin
            // Abort and normal completion both park in IDLE; only completion pulses done.
            state     <= IDLE;
            shift_reg <= '0;
            bits_left <= '0;
            divider   <= '0;
            gap_left  <= '0;
            led_out   <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            done      <= !abort;
`ifdef MORSE_QUEUE_EN
            hold_valid <= 1'b0;
`endif
         end else if (state != IDLE) begin
            divider <= tick_c ? DIV_RELOAD : divider - DIV_W'(1);
`ifdef MORSE_QUEUE_EN
            if (transfer_c) begin
               hold_valid <= 1'b1;
               hold_code  <= req_code;
               req_ready  <= 1'b0;
            end
`endif
            if (tick_c) begin
               if (state == SEND) begin
                  if (bits_left == LEN_W'(1)) begin
                     state    <= GAP;
                     gap_left <= GAP_LOAD;
                     led_out  <= 1'b0;
                  end else begin
                     shift_reg <= shift_reg << 1;
                     bits_left <= bits_left - LEN_W'(1);
                     led_out   <= shift_reg[PAT_W-2];
                  end
               end else begin
                  gap_left <= gap_left - GAP_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: doc/morse_tx_controller.md
Name: morse_tx_controller

Overview:
- Sequences Morse transmission of one letter per request onto a single LED output.
- Owns the symbol-time divider, the pattern ROM with per-letter lengths, the shift register and the inter-letter gap.
- Sits between switch/key front-end logic (or a future message sequencer) and the LED pin.
- Accepts letter requests through a valid/ready handshake and reports busy/done.

Parameters:
- TICK_DIV, 25000000, clock cycles per Morse time unit. Must be >= 1; 1 means one tick per cycle.
- GAP_TICKS, 3, time units of forced-low output after the last symbol. May be 0.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  letter request present.
- req_code  input  3  letter select: 0=S, 1=T, 2=U, 3=V, 4=W, 5=X, 6=Y, 7=Z.
- req_ready  output  1  controller can accept a request this cycle.
- abort  input  1  synchronous cancel of the current letter.
- led_out  output  1  Morse output; 1 = mark.
- busy  output  1  high in SEND or GAP.
- done  output  1  one-cycle pulse when a letter fully completes, including its gap.

Behaviour:
- Reset (async, active-high) forces the following, independent of clock:
  - state=IDLE, led_out=0, done=0, busy=0, shift register=0, counters=0.
  - req_ready=1 once reset deasserts.
- Pattern ROM: combinational, MSB-first, 1 bit per time unit. Dot=1, dash=111, intra-letter space=0.
  - S=10101 (length 5), T=111 (3), U=1010111 (7), V=101010111 (9).
  - W=101110111 (9), X=11101010111 (11), Y=1110101110111 (13), Z=11101110101 (11).
  - Stored left-aligned in a 16-bit shift register; length held in a 5-bit counter.
- Handshake: a transfer occurs when req_valid && req_ready at a rising edge. req_code is sampled only at that edge.
- FSM states: IDLE, SEND, GAP.
  - IDLE -> SEND on transfer. Same edge: load pattern, bits_left=length, divider=TICK_DIV-1.
  - SEND: led_out = shift_reg[15], registered. It is valid in the first SEND cycle.
  - Tick = divider==0; the divider then reloads TICK_DIV-1, otherwise it decrements.
  - Each tick in SEND: shift left by 1, bits_left-1.
  - Tick with bits_left==1: go to GAP with gap_left=GAP_TICKS and led_out=0. If GAP_TICKS==0, go directly to IDLE with done=1.
  - GAP: led_out=0. Each tick decrements gap_left. Tick with gap_left==1 -> IDLE and done=1 for exactly one cycle.
  - Each mark/space unit therefore lasts exactly TICK_DIV cycles.
- req_ready = (state==IDLE), base build. busy = (state!=IDLE).
- abort (sampled at edge, any state):
  - In SEND/GAP: -> IDLE, led_out=0, no done pulse, divider cleared.
  - In IDLE: ignored.
  - If abort and a transfer coincide in IDLE, the transfer wins.
- reset mid-letter: immediate return to reset values, no done pulse.
- Total latency from transfer edge to done: (length + GAP_TICKS) × TICK_DIV cycles.

Optional Feature:
- Macro: MORSE_QUEUE_EN.
- Defined:
  - One-entry holding register (hold_valid, hold_code).
  - req_ready = !hold_valid || (state==IDLE), so a request can be accepted during SEND/GAP into the holding register.
  - On letter completion with hold_valid=1: done still pulses, and the FSM goes directly to SEND loading hold_code, with no IDLE cycle.
  - hold_valid clears on that edge.
  - abort clears hold_valid as well.
- Not defined: no holding register; req_ready high only in IDLE.

Test Plan (TICK_DIV=4, GAP_TICKS=3 unless stated):
- Reset asserted mid-cycle -> led_out=0, busy=0, done=0 immediately. After release, req_ready=1.
- Request T (code 1) -> led_out=1 for 12 cycles starting the cycle after transfer, then 0 for 12 cycles. done high 1 cycle at cycle 24 after transfer; req_ready=1 that cycle.
- Request S (code 0) -> led_out waveform 1,0,1,0,1, each 4 cycles. done at cycle 32 after transfer.
- abort after 6 cycles of Y (code 6) -> led_out=0 and state IDLE the next cycle; done never pulses; next request T is accepted.
- TICK_DIV=1, GAP_TICKS=0, request Z -> led_out follows 11101110101 one bit per cycle; done on cycle 11; no gap cycles.
- MORSE_QUEUE_EN: request U, then W after 5 cycles -> W accepted (req_ready=1) while busy. done pulses at cycle 40; W's first mark starts on the next cycle with busy continuously high; second done at cycle 40+48.
